// File: rtl/gf_poly_reducer_if.sv
// Request/response bundle for the bit-serial GF(2^m) reducer: operands and
// start strobe travel one way, the remainder, completion pulse and busy
// flag travel back.
interface gf_poly_reducer_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int W  = DATA_WIDTH;
  localparam int MW = $clog2(W) + 1;

  logic            op_enable;
  logic [MW-1:0]   in_width;
  logic [W:0]      polyn_red_in;
  logic [2*W-1:0]  reduc_in;
  logic [W-1:0]    out_poly;
  logic            op_finish;
  logic            busy;

  // Requester side: drives operands and the start strobe.
  modport master (
    output op_enable, in_width, polyn_red_in, reduc_in,
    input  out_poly, op_finish, busy
  );

  // Reducer side: consumes operands, reports the remainder.
  modport slave (
    input  op_enable, in_width, polyn_red_in, reduc_in,
    output out_poly, op_finish, busy
  );
endinterface

// File: rtl/gf_poly_reducer.sv
// Bit-serial GF(2^m) modular reduction. A double-width carry-less product
// is reduced modulo an m-degree polynomial, one quotient bit per cycle from
// the top coefficient (x^(2m-1)) down to x^m, then the m-bit remainder is
// presented with a one-cycle op_finish pulse.
module gf_poly_reducer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  gf_poly_reducer_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int MW = $clog2(W) + 1;
  localparam int IW = $clog2(2 * W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   m_q, m_d;
  logic [W:0]      p_q, p_d;
  logic [2*W-1:0]  r_q, r_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    out_poly_q, out_poly_d;
  logic            op_finish_q, op_finish_d;

  logic [MW-1:0]   m_sel;
  logic [2*W-1:0]  r_next;

  // Next-state logic: capture operands on start, then one XOR-shift step per cycle.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    p_d         = p_q;
    r_d         = r_q;
    idx_d       = idx_q;
    out_poly_d  = out_poly_q;
    op_finish_d = 1'b0;
    r_next      = r_q;

    // A degree of zero or one beyond the datapath means "use the full width".
    m_sel = bus.in_width;
    if ((bus.in_width == '0) || (bus.in_width > MW'(W))) begin
      m_sel = MW'(W);
    end

    case (state_q)
      IDLE: begin
        if (bus.op_enable) begin
          state_d = RUN;
          m_d     = m_sel;
          // Keep P[m-1:0], force the leading coefficient, drop everything above.
          for (int i = 0; i <= W; i++) begin
            p_d[i] = (i < int'(m_sel)) ? bus.polyn_red_in[i] : (i == int'(m_sel));
          end
          // Only degrees up to 2m-1 take part in the reduction.
          for (int i = 0; i < 2 * W; i++) begin
            r_d[i] = (i < 2 * int'(m_sel)) ? bus.reduc_in[i] : 1'b0;
          end
          idx_d = IW'(2 * int'(m_sel) - 1);
        end
      end

      RUN: begin
        if (r_q[idx_q]) begin
          r_next = r_q ^ ((2 * W)'(p_q) << (idx_q - IW'(m_q)));
        end
        r_d   = r_next;
        idx_d = idx_q - IW'(1);
        // Once x^m is cleared every bit at or above m is zero, so the low
        // W bits are exactly the zero-extended remainder.
        if (idx_q == IW'(m_q)) begin
          state_d     = IDLE;
          out_poly_d  = r_next[W-1:0];
          op_finish_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      m_q         <= '0;
      p_q         <= '0;
      r_q         <= '0;
      idx_q       <= '0;
      out_poly_q  <= '0;
      op_finish_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      p_q         <= p_d;
      r_q         <= r_d;
      idx_q       <= idx_d;
      out_poly_q  <= out_poly_d;
      op_finish_q <= op_finish_d;
    end
  end

  assign bus.out_poly  = out_poly_q;
  assign bus.op_finish = op_finish_q;
  assign bus.busy      = (state_q == RUN);
endmodule

// File: tb/tb_gf_poly_reducer.sv
// Scoreboard bench for gf_poly_reducer: stimulus pushes hand-computed
// remainders and their due cycle, an independent monitor checks every
// op_finish against the queue head.
module tb_gf_poly_reducer;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] val;
    int           due;
  } exp_t;

  logic clk;
  logic reset;
  int   cycle;
  int   nChecks;
  int   nFail;
  exp_t sb[$];

  gf_poly_reducer_if #(.DATA_WIDTH(W)) bus ();

  gf_poly_reducer #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to timestamp starts and completions.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.op_finish) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_op_finish", 64'(bus.out_poly), 64'hDEAD_0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("out_poly", 64'(bus.out_poly), 64'(e.val));
        checkOutput("finish_cycle", 64'(cycle), 64'(e.due));
      end
    end
  end

  // Caller is positioned at a negedge; drive a start, push the expectation after the start edge.
  task automatic applyStimulus(input logic [5:0] inW, input logic [W:0] poly,
                               input logic [2*W-1:0] red, input logic [W-1:0] expVal,
                               input int mEff);
    exp_t e;
    bus.op_enable    = 1'b1;
    bus.in_width     = inW;
    bus.polyn_red_in = poly;
    bus.reduc_in     = red;
    @(posedge clk);
    #1;
    e.val = expVal;
    e.due = cycle + mEff;
    sb.push_back(e);
    bus.op_enable = 1'b0;
  endtask

  // Wait (bounded) for op_finish, counting busy cycles; optionally scramble inputs meanwhile.
  task automatic waitDone(input bit scramble, output int busyCount);
    bit done;
    done = 0;
    busyCount = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.op_finish) done = 1;
      else if (bus.busy) busyCount++;
      if (scramble && !done) begin
        bus.reduc_in     = {$urandom, $urandom};
        bus.polyn_red_in = {1'($urandom), $urandom};
        bus.in_width     = 6'($urandom);
      end
    end
    if (!done) checkOutput("timeout_op_finish", 64'd0, 64'd1);
  endtask

  initial begin
    int bc;
    nChecks          = 0;
    nFail            = 0;
    cycle            = 0;
    reset            = 1'b1;
    bus.op_enable    = 1'b0;
    bus.in_width     = '0;
    bus.polyn_red_in = '0;
    bus.reduc_in     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_out_poly", 64'(bus.out_poly), 64'd0);
    checkOutput("reset_op_finish", 64'(bus.op_finish), 64'd0);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] AES field reduction");
    applyStimulus(6'd8, 33'h11B, 64'h2B79, 32'hC1, 8);
    waitDone(0, bc);
    checkOutput("aes_busy_cycles", 64'(bc), 64'd8);

    $display("[TB] full width, clamped widths");
    applyStimulus(6'd32, {1'b1, 32'h8D}, 64'h1_0000_0000, 32'h8D, 32);
    waitDone(0, bc);
    checkOutput("w32_busy_cycles", 64'(bc), 64'd32);
    applyStimulus(6'd0, {1'b1, 32'h8D}, 64'h1_0000_0000, 32'h8D, 32);
    waitDone(0, bc);
    applyStimulus(6'd40, {1'b1, 32'h8D}, 64'h1_0000_0000, 32'h8D, 32);
    waitDone(0, bc);

    $display("[TB] passthrough and masking");
    applyStimulus(6'd8, 33'h11B, 64'h00A5, 32'hA5, 8);
    waitDone(0, bc);
    applyStimulus(6'd4, 33'h13, 64'hFF00, 32'h0, 4);
    waitDone(0, bc);
    applyStimulus(6'd4, 33'h1E3, 64'h10, 32'h3, 4);
    waitDone(0, bc);
    applyStimulus(6'd1, 33'h3, 64'h2, 32'h1, 1);
    waitDone(0, bc);
    checkOutput("m1_busy_cycles", 64'(bc), 64'd1);

    $display("[TB] start ignored while running");
    applyStimulus(6'd8, 33'h11B, 64'h2B79, 32'hC1, 8);
    repeat (3) @(negedge clk);
    bus.op_enable    = 1'b1;
    bus.in_width     = 6'd4;
    bus.polyn_red_in = 33'h13;
    bus.reduc_in     = 64'h00F0;
    @(negedge clk);
    bus.op_enable = 1'b0;
    waitDone(0, bc);

    $display("[TB] back-to-back start in the finish cycle");
    applyStimulus(6'd8, 33'h11B, 64'h00A5, 32'hA5, 8);
    waitDone(0, bc);
    applyStimulus(6'd8, 33'h11B, 64'h0100, 32'h1B, 8);
    waitDone(0, bc);
    checkOutput("b2b_busy_cycles", 64'(bc), 64'd8);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(6'd8, 33'h11B, 64'h2B79, 32'hC1, 8);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_op_finish", 64'(bus.op_finish), 64'd0);
    checkOutput("rst_out_poly", 64'(bus.out_poly), 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    applyStimulus(6'd8, 33'h11B, 64'h0100, 32'h1B, 8);
    waitDone(0, bc);

    $display("[TB] inputs scrambled during run");
    applyStimulus(6'd8, 33'h11B, 64'h2B79, 32'hC1, 8);
    waitDone(1, bc);
    bus.reduc_in     = '0;
    bus.polyn_red_in = '0;
    bus.in_width     = '0;

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
